top_module_transf_lineal: RTL and testbench



---
 rtl/transf_lineal_pkg.sv | 21 ++
 rtl/transf_lineal_mul.sv | 12 +
 rtl/top_module_transf_lineal.sv | 102 ++++++++++
 tb/tb_top_module_transf_lineal.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/transf_lineal_pkg.sv
// Shared types and constants for the Z-axis rotation of accelerometer samples.
// Sine/cosine arrive in Q2.13, so results carry an extra 2^13 scale.
package transf_lineal_pkg;

    localparam int FRAC_BITS = 13;
    localparam int ONE_Q13   = 8192;
    localparam int IN_W      = 16;
    localparam int RES_W     = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4
    } state_t;

    typedef logic signed [IN_W-1:0]  sample_t;
    typedef logic signed [RES_W-1:0] result_t;

endpackage

// File: rtl/transf_lineal_mul.sv
// Combinational signed 16x16 -> 32 multiplier shared by every product step.
module signed_mul16
    import transf_lineal_pkg::*;
(
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [RES_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/top_module_transf_lineal.sv
// Rotates (AcX, AcY) by a heading angle using one shared multiplier over four
// steps; AcZ is only rescaled. Busy stays high for exactly four cycles.
module top_module_transf_lineal
    import transf_lineal_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [IN_W-1:0]  AcX,
    input  logic signed [IN_W-1:0]  AcY,
    input  logic signed [IN_W-1:0]  AcZ,
    input  logic signed [IN_W-1:0]  sdseno,
    input  logic signed [IN_W-1:0]  sdcoseno,
    output logic signed [RES_W-1:0] XAc,
    output logic signed [RES_W-1:0] YAc,
    output logic signed [RES_W-1:0] ZAc,
    output logic                    Busy,
    output state_t                  state
);

    // Handshake: enable is sampled only in IDLE; while Busy=1 it is ignored
    // and nothing is queued. Results change only on the edge where Busy falls.

    sample_t x_l, y_l, z_l, sin_l, cos_l;
    result_t acc_x, acc_y;
    sample_t mul_a, mul_b;
    result_t prod;

    always_comb begin
        mul_a = x_l;
        mul_b = cos_l;
        case (state)
            P0: begin mul_a = x_l; mul_b = cos_l; end
            P1: begin mul_a = y_l; mul_b = sin_l; end
            P2: begin mul_a = x_l; mul_b = sin_l; end
            P3: begin mul_a = y_l; mul_b = cos_l; end
            default: begin mul_a = x_l; mul_b = cos_l; end
        endcase
    end

    signed_mul16 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            Busy  <= 1'b0;
            x_l   <= '0;
            y_l   <= '0;
            z_l   <= '0;
            sin_l <= '0;
            cos_l <= '0;
            acc_x <= '0;
            acc_y <= '0;
            XAc   <= '0;
            YAc   <= '0;
            ZAc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        x_l   <= AcX;
                        y_l   <= AcY;
                        z_l   <= AcZ;
                        sin_l <= sdseno;
                        cos_l <= sdcoseno;
                        Busy  <= 1'b1;
                        state <= P0;
                    end
                end
                P0: begin
                    acc_x <= prod;
                    state <= P1;
                end
                P1: begin
                    acc_x <= acc_x - prod;
                    state <= P2;
                end
                P2: begin
                    acc_y <= prod;
                    state <= P3;
                end
                P3: begin
                    // Sums wrap modulo 2^32 by design; no saturation.
                    XAc   <= acc_x;
                    YAc   <= acc_y + prod;
                    ZAc   <= result_t'(z_l) <<< FRAC_BITS;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_module_transf_lineal.sv
// Bench for the accelerometer rotation: reference model, per-cycle compare,
// result scoreboard and directed vectors with hand-computed results.
module tb_top_module_transf_lineal;
    import transf_lineal_pkg::*;

    logic               clk;
    logic               rst;
    logic               enable;
    logic signed [15:0] AcX, AcY, AcZ, sdseno, sdcoseno;
    logic signed [31:0] XAc, YAc, ZAc;
    logic               Busy;
    state_t             state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [95:0] exp_q[$];

    top_module_transf_lineal dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .AcX      (AcX),
        .AcY      (AcY),
        .AcZ      (AcZ),
        .sdseno   (sdseno),
        .sdcoseno (sdcoseno),
        .XAc      (XAc),
        .YAc      (YAc),
        .ZAc      (ZAc),
        .Busy     (Busy),
        .state    (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] rotate(input logic signed [15:0] x, y, z, s, c);
        longint xa, ya, za;
        xa = longint'(x) * longint'(c) - longint'(y) * longint'(s);
        ya = longint'(x) * longint'(s) + longint'(y) * longint'(c);
        za = longint'(z) * 8192;
        return {xa[31:0], ya[31:0], za[31:0]};
    endfunction

    // reference model: a transform takes four cycles, results land as it ends
    int          m_left    = 0;
    logic [95:0] m_out     = '0;
    logic [95:0] m_pending = '0;
    logic        m_started = 1'b0;
    logic        m_rst_edge = 1'b0;

    always @(posedge clk) begin
        m_started  = 1'b1;
        m_rst_edge = rst;
        if (rst) begin
            m_left = 0;
            m_out  = '0;
            exp_q.delete();
        end else if (m_left == 0) begin
            if (enable) begin
                m_pending = rotate(AcX, AcY, AcZ, sdseno, sdcoseno);
                exp_q.push_back(m_pending);
                m_left = 4;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_out = m_pending;
        end
    end

    // compare process: every cycle, plus a scoreboard pop at each completion
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (m_started) begin
            check("busy_cycle", 96'(Busy), 96'(m_left != 0));
            check("out_cycle", {XAc, YAc, ZAc}, m_out);
            if (prev_busy && !Busy && !m_rst_edge) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", {XAc, YAc, ZAc}, ~{XAc, YAc, ZAc});
                end else begin
                    check("scoreboard", {XAc, YAc, ZAc}, exp_q.pop_front());
                end
            end
            prev_busy = Busy;
        end
    end

    // driver tasks (called at a negedge)
    task automatic start_op(input logic signed [15:0] x, y, z, s, c);
        AcX = x; AcY = y; AcZ = z; sdseno = s; sdcoseno = c;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        while (Busy && busy_cycles < 20) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        int falls;
        int t[3];
        logic pb;

        rst = 1'b1; enable = 1'b0;
        AcX = '0; AcY = '0; AcZ = '0; sdseno = '0; sdcoseno = '0;
        repeat (10) @(negedge clk);
        check("reset_busy", 96'(Busy), 96'(0));
        check("reset_out", {XAc, YAc, ZAc}, 96'(0));
        check("reset_state", 96'(state), 96'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // small rotation
        start_op(16'sd1000, 16'sd1000, 16'sd0, 16'sd144, 16'sd8191);
        wait_done(bc);
        check("small_busy_len", 96'(bc), 96'(4));
        check("small_result", {XAc, YAc, ZAc}, {32'd8047000, 32'd8335000, 32'd0});

        // identity
        start_op(-16'sd5, 16'sd7, 16'sd3, 16'sd0, 16'sd8192);
        wait_done(bc);
        check("ident_busy_len", 96'(bc), 96'(4));
        check("ident_result", {XAc, YAc, ZAc}, {32'hFFFF6000, 32'h0000E000, 32'h00006000});

        // 90 degrees
        start_op(16'sd100, 16'sd0, -16'sd1, 16'sd8192, 16'sd0);
        wait_done(bc);
        check("rot90_result", {XAc, YAc, ZAc}, {32'h00000000, 32'h000C8000, 32'hFFFFE000});

        // extreme operands: X*cos - Y*sin = 2^30 + 32768*32767, still in range
        start_op(-16'sd32768, -16'sd32768, 16'sd0, 16'sd32767, -16'sd32768);
        wait_done(bc);
        check("extreme_result", {XAc, YAc, ZAc}, {32'h7FFF8000, 32'h00008000, 32'h0});

        // genuine wrap: Y sum is 2^30 + 2^30
        start_op(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
        wait_done(bc);
        check("wrap_result", {XAc, YAc, ZAc}, {32'h00000000, 32'h80000000, 32'hF0000000});

        // input changes and an enable pulse while busy
        start_op(16'sd2, 16'sd3, 16'sd4, 16'sd8192, 16'sd0);
        AcX = -16'sd1234; AcY = 16'sd999; AcZ = 16'sd77; sdseno = 16'sd11; sdcoseno = 16'sd22;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_done(bc);
        check("midop_busy_len", 96'(bc + 2), 96'(4));
        check("midop_result", {XAc, YAc, ZAc}, {32'hFFFFA000, 32'h00004000, 32'h00008000});
        repeat (3) begin
            @(negedge clk);
            check("midop_no_restart", 96'(Busy), 96'(0));
        end

        // enable held high: one result every 5 cycles
        AcX = 16'sd10; AcY = -16'sd10; AcZ = 16'sd1; sdseno = 16'sd0; sdcoseno = 16'sd8192;
        enable = 1'b1;
        falls = 0; pb = 1'b0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        for (int i = 0; i < 40 && falls < 3; i++) begin
            @(negedge clk);
            if (pb && !Busy) begin
                t[falls] = cyc;
                falls++;
                check("b2b_result", {XAc, YAc, ZAc}, {32'h00014000, 32'hFFFEC000, 32'h00002000});
            end
            pb = Busy;
        end
        enable = 1'b0;
        check("b2b_count", 96'(falls), 96'(3));
        check("b2b_gap1", 96'(t[1] - t[0]), 96'(5));
        check("b2b_gap2", 96'(t[2] - t[1]), 96'(5));
        wait_done(bc);
        @(negedge clk);

        // reset while in P2 discards the operation
        start_op(16'sd300, 16'sd400, 16'sd5, 16'sd100, 16'sd200);
        @(negedge clk);
        @(negedge clk);
        check("p2_state", 96'(state), 96'(P2));
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy", 96'(Busy), 96'(0));
        check("rstmid_out", {XAc, YAc, ZAc}, 96'(0));
        check("rstmid_state", 96'(state), 96'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // enable and rst together: reset wins
        rst = 1'b1;
        start_op(16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1);
        check("rst_enable_busy", 96'(Busy), 96'(0));
        rst = 1'b0;
        @(negedge clk);

        start_op(-16'sd5, 16'sd7, 16'sd3, 16'sd0, 16'sd8192);
        wait_done(bc);
        check("post_rst_busy_len", 96'(bc), 96'(4));
        check("post_rst_result", {XAc, YAc, ZAc}, {32'hFFFF6000, 32'h0000E000, 32'h00006000});

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
